// File: rtl/analog_sar_sequencer_if.sv
// Handshake/bus bundle between the SAR sequencer and its controller and analog front end.
interface analog_sar_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int CHW   = 2
);
   logic             start;
   logic             scan;
   logic [CHW-1:0]   ch;
   logic             comp_in;
   logic [CHW-1:0]   mux_sel;
   logic             sample;
   logic [WIDTH-1:0] dac_code;
   logic             busy;
   logic             valid;
   logic [WIDTH-1:0] data;
   logic [CHW-1:0]   data_ch;

   modport master (
      output start, scan, ch, comp_in,
      input  mux_sel, sample, dac_code, busy, valid, data, data_ch
   );

   modport slave (
      input  start, scan, ch, comp_in,
      output mux_sel, sample, dac_code, busy, valid, data, data_ch
   );
endinterface

// File: rtl/analog_sar_sequencer.sv
// Successive-approximation ADC sequencer: channel select, track/settle, binary search
// on the DAC trial code, result capture, optional round-robin scan over channels.
module analog_sar_sequencer #(
   parameter int WIDTH  = 8,
   parameter int NCH    = 4,
   parameter int SETTLE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   analog_sar_sequencer_if.slave bus
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

   state_t           state;
   logic [7:0]       cnt;       // settle countdown in SAMPLE, trial bit index in CONVERT
   logic [CHW-1:0]   chan;      // latched channel, also drives the mux directly
   logic             sample_q;
   logic             busy_q;
   logic             valid_q;
   logic [WIDTH-1:0] dac_q;
   logic [WIDTH-1:0] data_q;
   logic [CHW-1:0]   data_ch_q;

   logic [CHW-1:0]   ch_clamp;
   logic [CHW-1:0]   chan_nxt;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] kept;

   // Out-of-range channel requests saturate to the highest channel; scan wraps.
   always_comb begin
      ch_clamp = (bus.ch > CHW'(NCH-1)) ? CHW'(NCH-1) : bus.ch;
      chan_nxt = (chan == CHW'(NCH-1)) ? '0 : chan + CHW'(1);
   end

   // Current trial bit and the code after the comparator decision on it.
   always_comb begin
      mask = WIDTH'(1) << cnt;
      kept = bus.comp_in ? dac_q : (dac_q & ~mask);
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         chan      <= '0;
         sample_q  <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         dac_q     <= '0;
         data_q    <= '0;
         data_ch_q <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  chan     <= ch_clamp;
                  sample_q <= 1'b1;
                  busy_q   <= 1'b1;
                  cnt      <= 8'(SETTLE-1);
                  state    <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (cnt == 8'd0) begin
                  sample_q <= 1'b0;
                  dac_q    <= WIDTH'(1) << (WIDTH-1);
                  cnt      <= 8'(WIDTH-1);
                  state    <= CONVERT;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            CONVERT: begin
               if (cnt == 8'd0) begin
                  data_q    <= kept;
                  data_ch_q <= chan;
                  valid_q   <= 1'b1;
                  dac_q     <= '0;
                  state     <= DONE;
               end else begin
                  dac_q <= kept | (mask >> 1);
                  cnt   <= cnt - 8'd1;
               end
            end
            DONE: begin
               // scan is only looked at here, so dropping it mid-conversion finishes that one
               if (bus.scan) begin
                  chan     <= chan_nxt;
                  sample_q <= 1'b1;
                  cnt      <= 8'(SETTLE-1);
                  state    <= SAMPLE;
               end else begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mux_sel  = chan;
   assign bus.sample   = sample_q;
   assign bus.dac_code = dac_q;
   assign bus.busy     = busy_q;
   assign bus.valid    = valid_q;
   assign bus.data     = data_q;
   assign bus.data_ch  = data_ch_q;
endmodule

// File: tb/tb_analog_sar_sequencer.sv
// Directed bench for the SAR sequencer: single, stuck-rail, scan, start spam, reset abort, NCH=3 clamp.
module tb_analog_sar_sequencer;
   logic clk = 1'b0;
   logic rst;
   int   n_run  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   analog_sar_sequencer_if #(.WIDTH(8), .CHW(2)) bus ();
   analog_sar_sequencer_if #(.WIDTH(8), .CHW(2)) bus3 ();

   logic [7:0] vin [4];

   // Ideal comparator: analog input >= DAC level on the selected channel.
   assign bus.comp_in  = (vin[bus.mux_sel] >= bus.dac_code);
   assign bus3.comp_in = (8'h3C >= bus3.dac_code);

   analog_sar_sequencer #(.WIDTH(8), .NCH(4), .SETTLE(4)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   analog_sar_sequencer #(.WIDTH(8), .NCH(3), .SETTLE(4)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One single conversion on dut, start driven at cycle T, checked through T+14.
   task automatic run_conv(input logic [1:0] c, input logic [7:0] exp_d);
      logic [7:0] code, trial;
      int b;
      code = 8'h00;
      @(negedge clk);
      bus.start = 1'b1; bus.ch = c;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 1) bus.start = 1'b0;
         chk("sample", bus.sample, (k >= 1 && k <= 4));
         chk("valid", bus.valid, (k == 13));
         chk("busy", bus.busy, (k <= 13));
         if (k <= 12) chk("mux_sel", bus.mux_sel, c);
         if (k <= 4) chk("dac_sample", bus.dac_code, 8'h00);
         if (k >= 5 && k <= 12) begin
            b = 12 - k;
            trial = code | (8'h01 << b);
            chk("dac_trial", bus.dac_code, trial);
            if (vin[c] >= trial) code = trial;
         end
         if (k == 13) begin
            chk("data", bus.data, exp_d);
            chk("data_ch", bus.data_ch, c);
            chk("dac_done", bus.dac_code, 8'h00);
         end
      end
   endtask

   initial begin
      int nv, last;
      logic [7:0] exp_scan_d [5];
      logic [1:0] exp_scan_c [5];

      rst = 1'b1;
      bus.start = 1'b0; bus.scan = 1'b0; bus.ch = '0;
      bus3.start = 1'b0; bus3.scan = 1'b0; bus3.ch = '0;
      vin[0] = 8'h00; vin[1] = 8'hA5; vin[2] = 8'h5A; vin[3] = 8'hFF;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_mux", bus.mux_sel, 0);
      chk("rst_sample", bus.sample, 0);
      chk("rst_dac", bus.dac_code, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_data", bus.data, 0);
      chk("rst_data_ch", bus.data_ch, 0);
      rst = 1'b0;
      @(negedge clk);

      // single conversions: mid-scale, stuck low, stuck high
      run_conv(2'd1, 8'hA5);
      run_conv(2'd0, 8'h00);
      run_conv(2'd3, 8'hFF);
      run_conv(2'd2, 8'h5A);

      // scan from ch 2, drop scan at the fifth result
      vin[0] = 8'd10; vin[1] = 8'd20; vin[2] = 8'd30; vin[3] = 8'd40;
      exp_scan_c[0] = 2; exp_scan_c[1] = 3; exp_scan_c[2] = 0; exp_scan_c[3] = 1; exp_scan_c[4] = 2;
      exp_scan_d[0] = 30; exp_scan_d[1] = 40; exp_scan_d[2] = 10; exp_scan_d[3] = 20; exp_scan_d[4] = 30;
      @(negedge clk);
      bus.scan = 1'b1; bus.start = 1'b1; bus.ch = 2'd2;
      nv = 0; last = 0;
      for (int k = 1; k <= 85; k++) begin
         @(negedge clk);
         if (k == 1) bus.start = 1'b0;
         if (bus.valid) begin
            nv++;
            if (nv <= 5) begin
               chk("scan_ch", bus.data_ch, exp_scan_c[nv-1]);
               chk("scan_data", bus.data, exp_scan_d[nv-1]);
            end
            chk("scan_gap", k - last, 13);
            last = k;
            if (nv == 5) bus.scan = 1'b0;
         end
      end
      chk("scan_count", nv, 5);
      chk("scan_idle", bus.busy, 0);

      // scan dropped mid-conversion finishes the current one only
      @(negedge clk);
      bus.scan = 1'b1; bus.start = 1'b1; bus.ch = 2'd0;
      nv = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) bus.start = 1'b0;
         if (k == 6) bus.scan = 1'b0;
         if (bus.valid) begin
            nv++;
            chk("drop_time", k, 13);
            chk("drop_data", bus.data, 8'd10);
         end
      end
      chk("drop_count", nv, 1);
      chk("drop_idle", bus.busy, 0);

      // start held high: one conversion per IDLE visit
      @(negedge clk);
      bus.start = 1'b1; bus.ch = 2'd3;
      nv = 0;
      for (int k = 1; k <= 42; k++) begin
         @(negedge clk);
         if (k == 27) bus.start = 1'b0;
         if (k <= 27) chk("spam_valid", bus.valid, (k == 13 || k == 27));
         if (k == 14) chk("spam_idle", bus.busy, 0);
         if (k == 15) chk("spam_resample", bus.sample, 1);
         if (bus.valid) nv++;
      end
      chk("spam_count", nv, 2);

      // reset mid-CONVERT aborts; rst beats start
      vin[1] = 8'hA5;
      @(negedge clk);
      bus.start = 1'b1; bus.ch = 2'd1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) bus.start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("abort_mux", bus.mux_sel, 0);
      chk("abort_sample", bus.sample, 0);
      chk("abort_dac", bus.dac_code, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_valid", bus.valid, 0);
      chk("abort_data", bus.data, 0);
      chk("abort_data_ch", bus.data_ch, 0);
      bus.start = 1'b1;
      @(negedge clk);
      chk("rst_prio_busy", bus.busy, 0);
      chk("rst_prio_sample", bus.sample, 0);
      rst = 1'b0; bus.start = 1'b0;
      nv = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.valid) nv++;
      end
      chk("abort_no_valid", nv, 0);

      // NCH=3: ch=3 clamps to 2
      @(negedge clk);
      bus3.start = 1'b1; bus3.ch = 2'd3;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bus3.start = 1'b0;
            chk("n3_mux", bus3.mux_sel, 2);
         end
         chk("n3_valid", bus3.valid, (k == 13));
         if (k == 13) begin
            chk("n3_data_ch", bus3.data_ch, 2);
            chk("n3_data", bus3.data, 8'h3C);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/analog_sar_sequencer.md
ANALOG_SAR_SEQUENCER -- requirements
Module: analog_sar_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, conversion resolution in bits (legal 2..12).
REQ-002 Parameter NCH, default 4, number of analog mux channels (legal 1..8).
REQ-003 Parameter SETTLE, default 4, sample/track duration in clock cycles (legal 1..255).
REQ-004 Derived CHW = max(1, clog2(NCH)); all channel fields are CHW bits wide.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request a conversion; sampled only in IDLE.
REQ-008 scan  input  1  0 = single conversion, 1 = continuous round-robin scan over all channels.
REQ-009 ch  input  CHW  first channel to convert; latched on accepted start.
REQ-010 comp_in  input  1  comparator result, 1 = analog input >= DAC level; treated as already synchronous.
REQ-011 mux_sel  output  CHW  analog mux channel select.
REQ-012 sample  output  1  track switch enable, high only in SAMPLE.
REQ-013 dac_code  output  WIDTH  trial code to the capacitive/resistive DAC.
REQ-014 busy  output  1  high in SAMPLE, CONVERT and DONE.
REQ-015 valid  output  1  one-cycle pulse, data/data_ch valid.
REQ-016 data  output  WIDTH  last conversion result, held until next valid.
REQ-017 data_ch  output  CHW  channel of last result, held with data.

Function
REQ-018 State machine SHALL have exactly four states: IDLE, SAMPLE, CONVERT, DONE.
REQ-019 IDLE -> SAMPLE when start=1; channel latched = min(ch, NCH-1); mux_sel driven from latched channel.
REQ-020 SAMPLE SHALL last exactly SETTLE cycles with sample=1, dac_code=0, then -> CONVERT.
REQ-021 On CONVERT entry dac_code = 1 << (WIDTH-1); sample=0.
REQ-022 CONVERT SHALL last exactly WIDTH cycles; in cycle k (k=0..WIDTH-1) the trial bit is WIDTH-1-k.
REQ-023 At end of each CONVERT cycle the trial bit SHALL be kept if comp_in=1, cleared if comp_in=0, and the next lower bit set (none after bit 0).
REQ-024 After the last CONVERT cycle -> DONE; in DONE valid=1, data=final code, data_ch=latched channel.
REQ-025 Latency: start accepted at cycle T gives valid=1 at cycle T+SETTLE+WIDTH+1.
REQ-026 DONE -> SAMPLE on channel (chan+1) mod NCH if scan=1 during DONE, else -> IDLE.
REQ-027 scan is sampled only in DONE; deasserting scan mid-conversion completes the current conversion then returns to IDLE.
REQ-028 start while not in IDLE SHALL be ignored with no queuing; earliest re-accept in single mode is T+SETTLE+WIDTH+2.
REQ-029 mux_sel SHALL be stable throughout SAMPLE and CONVERT of a conversion.
REQ-030 With NCH=1 scan repeatedly converts channel 0.
REQ-031 dac_code SHALL be 0 in IDLE and DONE.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, mux_sel=0, sample=0, dac_code=0, busy=0, valid=0, data=0, data_ch=0.
REQ-033 Reset mid-conversion SHALL abort without asserting valid; data keeps reset value 0.
REQ-034 rst has priority over start in the same cycle.

Verification (WIDTH=8, NCH=4, SETTLE=4 unless noted)
REQ-035 Comparator model vin=0xA5, start at T, ch=1 -> sample high T+1..T+4, valid at T+13, data=0xA5, data_ch=1, busy low at T+14.
REQ-036 vin=0x00 and vin=0xFF (comp_in stuck 0 / stuck 1) -> data=0x00 and 0xFF respectively, dac_code sequence 0x80,0x40,.. / 0x80,0xC0,..,0xFF.
REQ-037 scan=1, start ch=2, per-channel vin {10,20,30,40} -> valid results data_ch 2,3,0,1,2 with data 30,40,10,20,30, valids 13 cycles apart; drop scan -> IDLE after current result.
REQ-038 start pulsed every cycle while busy -> exactly one conversion per IDLE visit, no extra valid.
REQ-039 rst asserted at T+8 (mid CONVERT) -> next cycle all outputs at reset values, no valid pulse.
REQ-040 NCH=3 (CHW=2), start with ch=3 -> mux_sel=2, data_ch=2.
